led_meter_ctrl: RTL and testbench

Level-meter controller that sits in front of the LED bar-graph encoder and decides what it shows. It takes a stream of 8-bit amplitude samples and produces three registered outputs:
- a smoothed display level with instant attack and timed linear decay;
- a peak-hold value with hold time and fall-off;
- a one-hot "peak dot" aligned to the bar segments.

All timing derives from an internal tick divider.

---
 rtl/led_meter_ctrl.sv | 132 +++++++++++++
 tb/tb_led_meter_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_meter_ctrl.sv
// LED level-meter controller: smoothed level with instant attack and timed decay,
// peak-hold with hold time and fall-off, and a one-hot peak dot for the bar graph.
module led_meter_ctrl #(
  parameter int unsigned TICK_DIV   = 500000,
  parameter int unsigned HOLD_TICKS = 100,
  parameter int unsigned DECAY_STEP = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  input  logic       clear_peak,
  output logic [7:0] level_out,
  output logic [7:0] peak_out,
  output logic [7:0] peak_led
);

  localparam int unsigned TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HCW = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {
    TRACK = 2'd0,
    HOLD  = 2'd1,
    FALL  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]     level_q, level_d;
  logic [7:0]     peak_q, peak_d;
  logic [7:0]     led_q, led_d;

  logic           tick_c;
  logic [7:0]     level_base_c;
  logic [7:0]     peak_dec_c;
  logic [7:0]     peak_fall_c;
  logic [HCW-1:0] hold_inc_c;
  logic [3:0]     seg_cnt_c;

  // Subtract the decay step, computed one bit wider so it clamps at zero.
  function automatic logic [7:0] dec8(input logic [7:0] x);
    logic [8:0] diff;
    diff = {1'b0, x} - 9'(DECAY_STEP);
    return diff[8] ? 8'd0 : diff[7:0];
  endfunction

  // Tick divider and level path.
  always_comb begin
    tick_c       = (tick_cnt_q == TCW'(TICK_DIV - 1));
    tick_cnt_d   = tick_c ? '0 : tick_cnt_q + TCW'(1);
    level_base_c = tick_c ? dec8(level_q) : level_q;
    level_d      = (sample_valid && (sample > level_base_c)) ? sample : level_base_c;
  end

  // Peak FSM; every decision looks at the level being loaded this cycle.
  always_comb begin
    state_d     = state_q;
    peak_d      = peak_q;
    hold_cnt_d  = hold_cnt_q;
    hold_inc_c  = hold_cnt_q + HCW'(1);
    peak_dec_c  = dec8(peak_q);
    peak_fall_c = (peak_dec_c > level_d) ? peak_dec_c : level_d;

    if (clear_peak) begin
      peak_d     = level_d;
      state_d    = TRACK;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        TRACK: begin
          if (level_d >= peak_q) begin
            peak_d = level_d;
          end else begin
            state_d    = HOLD;
            hold_cnt_d = '0;
          end
        end
        HOLD: begin
          if (level_d >= peak_q) begin
            peak_d     = level_d;
            hold_cnt_d = '0;
          end else if (tick_c) begin
            hold_cnt_d = hold_inc_c;
            if (hold_inc_c == HCW'(HOLD_TICKS)) state_d = FALL;
          end
        end
        FALL: begin
          if (level_d >= peak_q) begin
            peak_d     = level_d;
            state_d    = HOLD;
            hold_cnt_d = '0;
          end else if (tick_c) begin
            peak_d = peak_fall_c;
            if (peak_fall_c == level_d) state_d = TRACK;
          end
        end
        default: begin
          state_d    = TRACK;
          hold_cnt_d = '0;
        end
      endcase
    end

    // Lit segment count rounds the top nibble; the dot marks the highest lit segment.
    seg_cnt_c = 4'((5'(peak_d[7:4]) + 5'd1) >> 1);
    led_d     = 8'((9'd1 << seg_cnt_c) >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TRACK;
      tick_cnt_q <= '0;
      hold_cnt_q <= '0;
      level_q    <= '0;
      peak_q     <= '0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      peak_q     <= peak_d;
      led_q      <= led_d;
    end
  end

  assign level_out = level_q;
  assign peak_out  = peak_q;
  assign peak_led  = led_q;

endmodule

// File: tb/tb_led_meter_ctrl.sv
// Directed bench for led_meter_ctrl with TICK_DIV=4, HOLD_TICKS=2, DECAY_STEP=16.
// Expected values are {level_out, peak_out, peak_led} triples worked out by hand.
module tb_led_meter_ctrl;

  logic       clk;
  logic       rst;
  logic       sample_valid;
  logic [7:0] sample;
  logic       clear_peak;
  logic [7:0] level_out;
  logic [7:0] peak_out;
  logic [7:0] peak_led;

  int checks;
  int errors;
  bit inv_en;

  led_meter_ctrl #(
    .TICK_DIV  (4),
    .HOLD_TICKS(2),
    .DECAY_STEP(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample      (sample),
    .clear_peak  (clear_peak),
    .level_out   (level_out),
    .peak_out    (peak_out),
    .peak_led    (peak_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle; the peak >= level invariant is checked every cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (inv_en) begin
      checks++;
      if (peak_out < level_out) begin
        errors++;
        $display("FAIL invariant: peak_out %h below level_out %h at %0t", peak_out, level_out, $time);
      end
    end
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Leaves the bench just after the release edge R; edge R+4 is the first tick.
  task automatic do_reset();
    rst = 1'b1; sample_valid = 1'b0; clear_peak = 1'b0; sample = 8'h00;
    cycn(2);
    rst = 1'b0;
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h000000) begin
      errors++;
      $display("FAIL do_reset: got %h want %h", {level_out, peak_out, peak_led}, 24'h000000);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sample_valid = 1'b1; sample = 8'd200; clear_peak = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      inv_en = 1'b1;
      checks++;
      if ({level_out, peak_out, peak_led} !== 24'h000000) begin
        errors++;
        $display("FAIL reset_hold%0d: got %h want %h", i, {level_out, peak_out, peak_led}, 24'h000000);
      end
    end
    rst = 1'b0; sample = 8'h40;
    cyc();
    sample_valid = 1'b0;
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h404002) begin
      errors++;
      $display("FAIL reset_load: got %h want %h", {level_out, peak_out, peak_led}, 24'h404002);
    end
    cycn(2);
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h404002) begin
      errors++;
      $display("FAIL reset_pretick: got %h want %h", {level_out, peak_out, peak_led}, 24'h404002);
    end
    cyc();
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h304002) begin
      errors++;
      $display("FAIL reset_first_tick: got %h want %h", {level_out, peak_out, peak_led}, 24'h304002);
    end
  endtask

  task automatic test_attack();
    do_reset();
    sample_valid = 1'b1; sample = 8'hF0;
    cyc();
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'hF0F080) begin
      errors++;
      $display("FAIL attack_f0: got %h want %h", {level_out, peak_out, peak_led}, 24'hF0F080);
    end
    sample = 8'h10;
    cyc();
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'hF0F080) begin
      errors++;
      $display("FAIL attack_small: got %h want %h", {level_out, peak_out, peak_led}, 24'hF0F080);
    end
    sample = 8'hFF;
    cyc();
    sample_valid = 1'b0;
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'hFFFF80) begin
      errors++;
      $display("FAIL attack_full_scale: got %h want %h", {level_out, peak_out, peak_led}, 24'hFFFF80);
    end
    cyc();
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'hEFFF80) begin
      errors++;
      $display("FAIL attack_decay_ff: got %h want %h", {level_out, peak_out, peak_led}, 24'hEFFF80);
    end
  endtask

  task automatic test_decay();
    do_reset();
    sample_valid = 1'b1; sample = 8'h25;
    cyc();
    sample_valid = 1'b0;
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h252501) begin
      errors++;
      $display("FAIL decay_load: got %h want %h", {level_out, peak_out, peak_led}, 24'h252501);
    end
    cycn(2);
    sample_valid = 1'b1; sample = 8'h10;
    cyc();
    sample_valid = 1'b0;
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h152501) begin
      errors++;
      $display("FAIL decay_tick1: got %h want %h", {level_out, peak_out, peak_led}, 24'h152501);
    end
    cycn(4);
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h052501) begin
      errors++;
      $display("FAIL decay_tick2: got %h want %h", {level_out, peak_out, peak_led}, 24'h052501);
    end
    cycn(4);
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h002501) begin
      errors++;
      $display("FAIL decay_sat: got %h want %h", {level_out, peak_out, peak_led}, 24'h002501);
    end
    cycn(4);
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h001501) begin
      errors++;
      $display("FAIL decay_sat_hold: got %h want %h", {level_out, peak_out, peak_led}, 24'h001501);
    end
    cycn(8);
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h000000) begin
      errors++;
      $display("FAIL decay_peak_floor: got %h want %h", {level_out, peak_out, peak_led}, 24'h000000);
    end
  endtask

  task automatic test_peak_fall();
    do_reset();
    sample_valid = 1'b1; sample = 8'hA0;
    cyc();
    sample_valid = 1'b0;
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'hA0A010) begin
      errors++;
      $display("FAIL fall_load: got %h want %h", {level_out, peak_out, peak_led}, 24'hA0A010);
    end
    cycn(3);
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h90A010) begin
      errors++;
      $display("FAIL fall_t1: got %h want %h", {level_out, peak_out, peak_led}, 24'h90A010);
    end
    cycn(4);
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h80A010) begin
      errors++;
      $display("FAIL fall_t2: got %h want %h", {level_out, peak_out, peak_led}, 24'h80A010);
    end
    cycn(7);
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h70A010) begin
      errors++;
      $display("FAIL fall_t3_held: got %h want %h", {level_out, peak_out, peak_led}, 24'h70A010);
    end
    cyc();
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h609010) begin
      errors++;
      $display("FAIL fall_t4: got %h want %h", {level_out, peak_out, peak_led}, 24'h609010);
    end
    cycn(4);
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h508008) begin
      errors++;
      $display("FAIL fall_t5: got %h want %h", {level_out, peak_out, peak_led}, 24'h508008);
    end
    cycn(4);
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h407008) begin
      errors++;
      $display("FAIL fall_t6: got %h want %h", {level_out, peak_out, peak_led}, 24'h407008);
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    sample_valid = 1'b1; sample = 8'hA0;
    cyc();
    sample_valid = 1'b0;
    cycn(19);
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h508008) begin
      errors++;
      $display("FAIL retrig_setup: got %h want %h", {level_out, peak_out, peak_led}, 24'h508008);
    end
    sample_valid = 1'b1; sample = 8'hC0;
    cyc();
    sample_valid = 1'b0;
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'hC0C020) begin
      errors++;
      $display("FAIL retrig_load: got %h want %h", {level_out, peak_out, peak_led}, 24'hC0C020);
    end
    cycn(7);
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'hA0C020) begin
      errors++;
      $display("FAIL retrig_held: got %h want %h", {level_out, peak_out, peak_led}, 24'hA0C020);
    end
    cycn(4);
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h90B020) begin
      errors++;
      $display("FAIL retrig_fall: got %h want %h", {level_out, peak_out, peak_led}, 24'h90B020);
    end
  endtask

  task automatic test_clear_peak();
    do_reset();
    sample_valid = 1'b1; sample = 8'hB0;
    cyc();
    sample_valid = 1'b0;
    cycn(11);
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h80B020) begin
      errors++;
      $display("FAIL clear_setup: got %h want %h", {level_out, peak_out, peak_led}, 24'h80B020);
    end
    cycn(3);
    clear_peak = 1'b1; sample_valid = 1'b1; sample = 8'h30;
    cyc();
    clear_peak = 1'b0; sample_valid = 1'b0;
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h707008) begin
      errors++;
      $display("FAIL clear_tick_sample: got %h want %h", {level_out, peak_out, peak_led}, 24'h707008);
    end
    cycn(4);
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h607008) begin
      errors++;
      $display("FAIL clear_then_hold: got %h want %h", {level_out, peak_out, peak_led}, 24'h607008);
    end
    cycn(8);
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h407008) begin
      errors++;
      $display("FAIL clear_hold_end: got %h want %h", {level_out, peak_out, peak_led}, 24'h407008);
    end
    cycn(4);
    checks++;
    if ({level_out, peak_out, peak_led} !== 24'h306004) begin
      errors++;
      $display("FAIL clear_fall: got %h want %h", {level_out, peak_out, peak_led}, 24'h306004);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    inv_en = 1'b0;
    rst = 1'b1;
    sample_valid = 1'b0;
    sample = 8'h00;
    clear_peak = 1'b0;
    test_reset();
    test_attack();
    test_decay();
    test_peak_fall();
    test_retrigger();
    test_clear_peak();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
